// File: rtl/pkg_control_fsm.sv
// Shared definitions for the multicycle core: FSM state encoding, the two
// supported major opcodes and the ALU operation codes.
package pkg_control_fsm;

  typedef enum logic [5:0] {
    FETCH      = 6'd0,
    FETCH_WAIT = 6'd1,
    DECODE     = 6'd2,
    EXECUTEI   = 6'd3,
    EXECUTER   = 6'd4,
    ALUWB      = 6'd5
  } state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // funct7[5] selects SUB only for register-register ops; for immediates that
  // bit is part of the immediate, except for the shift-right family.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_r);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/top_alu.sv
// Combinational 32-bit integer ALU with wrap-around arithmetic.
module top_alu
  import pkg_control_fsm::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_out
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;

  assign a     = i_a;
  assign b     = i_b;
  assign o_out = out;

  always_comb begin
    out = 32'd0;
    case (i_op)
      ALU_ADD:  out = a + b;
      ALU_SUB:  out = a - b;
      ALU_SLL:  out = a << b[4:0];
      ALU_SLT:  out = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: out = {31'd0, (a < b)};
      ALU_XOR:  out = a ^ b;
      ALU_SRL:  out = a >> b[4:0];
      ALU_SRA:  out = $signed(a) >>> b[4:0];
      ALU_OR:   out = a | b;
      ALU_AND:  out = a & b;
      default:  out = 32'd0;
    endcase
  end

endmodule

// File: rtl/top_control_fsm.sv
// Multicycle sequencer: FETCH, FETCH_WAIT, DECODE, EXECUTEI/EXECUTER, ALUWB.
module top_control_fsm
  import pkg_control_fsm::*;
(
  input  logic       clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  output logic [5:0] o_state,
  output logic       o_ir_load,
  output logic       o_pc_inc,
  output logic       o_alu_latch,
  output logic       o_rf_we
);

  state_t current_state;
  state_t w_next_state;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      current_state <= FETCH;
    end else begin
      current_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = current_state;
    o_ir_load    = 1'b0;
    o_pc_inc     = 1'b0;
    o_alu_latch  = 1'b0;
    o_rf_we      = 1'b0;
    case (current_state)
      FETCH: w_next_state = FETCH_WAIT;
      FETCH_WAIT: begin
        o_ir_load    = 1'b1;
        o_pc_inc     = 1'b1;
        w_next_state = DECODE;
      end
      DECODE: begin
        if (i_opcode == OP_IMM) begin
          w_next_state = EXECUTEI;
        end else if (i_opcode == OP) begin
          w_next_state = EXECUTER;
        end else begin
          w_next_state = FETCH;
        end
      end
      EXECUTEI, EXECUTER: begin
        o_alu_latch  = 1'b1;
        w_next_state = ALUWB;
      end
      ALUWB: begin
        // A reset landing on the writeback cycle cancels the register write.
        o_rf_we      = ~i_reset;
        w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  assign o_state = current_state;

endmodule

// File: rtl/top_core.sv
// Multicycle RV32I OP/OP-IMM core; talks to a word-addressed memory whose
// depth is a power of two, so the word index is a plain slice of the PC.
module top_core
  import pkg_control_fsm::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0,
  localparam int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_reset,
  output logic [AW-1:0] o_mem_addr,
  input  logic [31:0]   i_mem_data
);

  logic [6:0]  opcode;
  logic [31:0] w_pc;
  logic [2:0]  w_funct3;
  logic        w_funct7_b5;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_out;
  logic [3:0]  w_alu_op;
  logic        w_is_r;
  logic [5:0]  w_state;
  logic        w_ir_load;
  logic        w_pc_inc;
  logic        w_alu_latch;
  logic        w_rf_we;
  logic [31:0] r_alu_out;

  top_fetch #(.RESET_PC(RESET_PC)) fetch (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_pc_inc (w_pc_inc),
    .o_pc     (w_pc)
  );

  top_decode instruction_decode (
    .clk         (clk),
    .i_load      (w_ir_load),
    .i_mem_data  (i_mem_data),
    .o_opcode    (opcode),
    .o_funct3    (w_funct3),
    .o_funct7_b5 (w_funct7_b5),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_rd        (w_rd),
    .o_imm       (w_imm)
  );

  top_regfile RegFile (
    .clk   (clk),
    .i_rs1 (w_rs1),
    .i_rs2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_rf_we),
    .i_rd  (w_rd),
    .i_wd  (r_alu_out)
  );

  assign w_is_r   = (opcode == OP);
  assign w_alu_b  = w_is_r ? w_rd2 : w_imm;
  assign w_alu_op = alu_op_decode(w_funct3, w_funct7_b5, w_is_r);

  top_alu alu (
    .i_op  (w_alu_op),
    .i_a   (w_rd1),
    .i_b   (w_alu_b),
    .o_out (w_alu_out)
  );

  top_control_fsm control_fsm (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_opcode    (opcode),
    .o_state     (w_state),
    .o_ir_load   (w_ir_load),
    .o_pc_inc    (w_pc_inc),
    .o_alu_latch (w_alu_latch),
    .o_rf_we     (w_rf_we)
  );

  always_ff @(posedge clk) begin
    if (w_alu_latch) begin
      r_alu_out <= w_alu_out;
    end
  end

  assign o_mem_addr = w_pc[AW+1:2];

endmodule

// File: rtl/top_decode.sv
// Instruction register plus field extraction for R-type and I-type formats.
module top_decode (
  input  logic        clk,
  input  logic        i_load,
  input  logic [31:0] i_mem_data,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic        o_funct7_b5,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm
);

  logic [31:0] r_instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_ext;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_instr <= i_mem_data;
    end
  end

  assign rs1     = r_instr[19:15];
  assign rs2     = r_instr[24:20];
  assign rd      = r_instr[11:7];
  assign imm_ext = {{20{r_instr[31]}}, r_instr[31:20]};

  assign o_opcode    = r_instr[6:0];
  assign o_funct3    = r_instr[14:12];
  assign o_funct7_b5 = r_instr[30];
  assign o_rs1       = rs1;
  assign o_rs2       = rs2;
  assign o_rd        = rd;
  assign o_imm       = imm_ext;

endmodule

// File: rtl/top_fetch.sv
// Program counter: loads RESET_PC on reset, advances by one word per fetch.
module top_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_pc_inc,
  output logic [31:0] o_pc
);

  logic [31:0] pc_cur;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pc_cur <= RESET_PC;
    end else if (i_pc_inc) begin
      pc_cur <= pc_cur + 32'd4;
    end
  end

  assign o_pc = pc_cur;

endmodule

// File: rtl/top_memory.sv
// Unified instruction/data memory with registered read; the write port serves
// as a load path and is idle in this system.
module top_memory #(
  parameter int  MEM_WORDS = 256,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] M [MEM_WORDS];
  logic [31:0] r_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      M[i_waddr] <= i_wdata;
    end
    r_data <= M[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/top_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port; x0 always reads zero and any write to it stores zero.
module top_regfile (
  input  logic        clk,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wd
);

  logic [31:0] RFMem [32];

  assign o_rd1 = (i_rs1 == 5'd0) ? 32'd0 : RFMem[i_rs1];
  assign o_rd2 = (i_rs2 == 5'd0) ? 32'd0 : RFMem[i_rs2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      RFMem[i_rd] <= (i_rd == 5'd0) ? 32'd0 : i_wd;
    end
  end

endmodule

// File: rtl/top.sv
// System top: one multicycle core plus its unified memory; only clock and
// reset leave the chip.
module top #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic clk,
  input  logic reset
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_data;

  top_core #(
    .MEM_WORDS (MEM_WORDS),
    .RESET_PC  (RESET_PC)
  ) core (
    .clk        (clk),
    .i_reset    (reset),
    .o_mem_addr (w_mem_addr),
    .i_mem_data (w_mem_data)
  );

  top_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk     (clk),
    .i_addr  (w_mem_addr),
    .o_data  (w_mem_data),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata (32'd0)
  );

endmodule

// File: tb/tb_top.sv
// Directed bench for the multicycle core: expectations are queued before each
// program runs and popped as the matching state is reached.
module tb_top;

  localparam logic [5:0] S_FETCH = 6'd0;
  localparam logic [5:0] S_FW    = 6'd1;
  localparam logic [5:0] S_DEC   = 6'd2;
  localparam logic [5:0] S_EXI   = 6'd3;
  localparam logic [5:0] S_EXR   = 6'd4;
  localparam logic [5:0] S_WB    = 6'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  top #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic [31:0] tab_instr [11];
  logic [31:0] tab_exp   [11];

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) begin
        n_pass++;
        $display("check %-16s observed %h", e.tag, obs);
      end else begin
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the core in reset for one edge so preloads can be placed safely.
  task automatic hold();
    reset = 1'b1;
    tick();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) dut.memory.M[k] = 32'h0;
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.core.control_fsm.current_state);
  endfunction

  function automatic logic [31:0] pc();
    return dut.core.fetch.pc_cur;
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd13, 5'd12, f3, 5'd14, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd12, f3, 5'd14, 7'b0010011};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- NOP (addi x0,x0,0) ----------------
    hold();
    clear_mem();
    dut.memory.M[0] = 32'h00000013;
    dut.core.RegFile.RFMem[0] = 32'h01010101;
    expect_val("nop_s0_fetch", 32'(S_FETCH));
    expect_val("nop_pc_reset", 32'h0);
    expect_val("nop_s1_fw",    32'(S_FW));
    expect_val("nop_s2_dec",   32'(S_DEC));
    expect_val("nop_opcode",   32'h13);
    expect_val("nop_rs1",      32'h0);
    expect_val("nop_rd",       32'h0);
    expect_val("nop_imm",      32'h0);
    expect_val("nop_s3_exi",   32'(S_EXI));
    expect_val("nop_alu_a",    32'h0);
    expect_val("nop_alu_b",    32'h0);
    expect_val("nop_alu_out",  32'h0);
    expect_val("nop_s4_wb",    32'(S_WB));
    expect_val("nop_s5_fetch", 32'(S_FETCH));
    expect_val("nop_s6_fw",    32'(S_FW));
    expect_val("nop_x0_zero",  32'h0);
    expect_val("nop_pc4",      32'h4);
    reset = 1'b0;
    check(st());
    check(pc());
    tick(); check(st());
    tick(); check(st());
    check(32'(dut.core.opcode));
    check(32'(dut.core.instruction_decode.rs1));
    check(32'(dut.core.instruction_decode.rd));
    check(dut.core.instruction_decode.imm_ext);
    tick(); check(st());
    check(dut.core.alu.a);
    check(dut.core.alu.b);
    check(dut.core.alu.out);
    tick(); check(st());
    tick(); check(st());
    tick(); check(st());
    check(dut.core.RegFile.RFMem[0]);
    check(pc());

    // ---------------- addi x1,x0,-5 ----------------
    hold();
    clear_mem();
    dut.memory.M[0] = 32'hFFB00093;
    dut.core.RegFile.RFMem[1] = 32'h0;
    expect_val("addi_imm",  32'hFFFFFFFB);
    expect_val("addi_rd",   32'h1);
    expect_val("addi_out",  32'hFFFFFFFB);
    expect_val("addi_x1",   32'hFFFFFFFB);
    reset = 1'b0;
    ticks(2);
    check(dut.core.instruction_decode.imm_ext);
    check(32'(dut.core.instruction_decode.rd));
    tick(); check(dut.core.alu.out);
    ticks(2); check(dut.core.RegFile.RFMem[1]);

    // ---------------- R-type add / sub ----------------
    hold();
    clear_mem();
    dut.memory.M[0] = 32'h00310233;
    dut.memory.M[1] = 32'h403102B3;
    dut.core.RegFile.RFMem[2] = 32'd7;
    dut.core.RegFile.RFMem[3] = 32'd9;
    dut.core.RegFile.RFMem[4] = 32'h0;
    dut.core.RegFile.RFMem[5] = 32'h0;
    expect_val("add_state_exr", 32'(S_EXR));
    expect_val("add_alu_a",     32'd7);
    expect_val("add_alu_b",     32'd9);
    expect_val("add_alu_out",   32'd16);
    expect_val("add_x4",        32'd16);
    expect_val("sub_state_exr", 32'(S_EXR));
    expect_val("sub_alu_out",   32'hFFFFFFFE);
    expect_val("sub_x5",        32'hFFFFFFFE);
    reset = 1'b0;
    ticks(3); check(st());
    check(dut.core.alu.a);
    check(dut.core.alu.b);
    check(dut.core.alu.out);
    ticks(2); check(dut.core.RegFile.RFMem[4]);
    ticks(3); check(st());
    check(dut.core.alu.out);
    ticks(2); check(dut.core.RegFile.RFMem[5]);

    // ---------------- unknown opcode ----------------
    hold();
    clear_mem();
    dut.core.RegFile.RFMem[0] = 32'hDEADBEEF;
    expect_val("unk_state_dec",   32'(S_DEC));
    expect_val("unk_state_fetch", 32'(S_FETCH));
    expect_val("unk_state_fw",    32'(S_FW));
    expect_val("unk_pc4",         32'h4);
    expect_val("unk_no_rf_write", 32'hDEADBEEF);
    reset = 1'b0;
    ticks(2); check(st());
    tick(); check(st());
    tick(); check(st());
    check(pc());
    check(dut.core.RegFile.RFMem[0]);

    // ---------------- reset mid-instruction ----------------
    hold();
    clear_mem();
    dut.memory.M[0] = 32'h00500313;
    dut.core.RegFile.RFMem[6] = 32'h12345678;
    expect_val("rst_in_exi",      32'(S_EXI));
    expect_val("rst_state_fetch", 32'(S_FETCH));
    expect_val("rst_pc0",         32'h0);
    expect_val("rst_rd_kept",     32'h12345678);
    expect_val("rst_held_fetch",  32'(S_FETCH));
    expect_val("rst_in_wb",       32'(S_WB));
    expect_val("rst_wb_fetch",    32'(S_FETCH));
    expect_val("rst_wb_rd_kept",  32'h12345678);
    expect_val("rst_rerun_x6",    32'd5);
    reset = 1'b0;
    ticks(3); check(st());
    reset = 1'b1;
    tick(); check(st());
    check(pc());
    check(dut.core.RegFile.RFMem[6]);
    tick(); check(st());
    reset = 1'b0;
    ticks(4); check(st());
    reset = 1'b1;
    tick(); check(st());
    check(dut.core.RegFile.RFMem[6]);
    reset = 1'b0;
    ticks(5); check(dut.core.RegFile.RFMem[6]);

    // ---------------- three consecutive addi ----------------
    hold();
    clear_mem();
    dut.memory.M[0] = 32'h00100393;
    dut.memory.M[1] = 32'h00238413;
    dut.memory.M[2] = 32'hFFD40493;
    dut.core.RegFile.RFMem[7] = 32'hAAAAAAAA;
    dut.core.RegFile.RFMem[8] = 32'hAAAAAAAA;
    dut.core.RegFile.RFMem[9] = 32'hAAAAAAAA;
    expect_val("seq_dec3_state", 32'(S_DEC));
    expect_val("seq_dec3_pc12",  32'd12);
    expect_val("seq_x7",         32'd1);
    expect_val("seq_x8",         32'd3);
    expect_val("seq_x9",         32'd0);
    reset = 1'b0;
    ticks(12); check(st());
    check(pc());
    ticks(3);
    check(dut.core.RegFile.RFMem[7]);
    check(dut.core.RegFile.RFMem[8]);
    check(dut.core.RegFile.RFMem[9]);

    // ---------------- ALU operation table, x12=FFFFFFF0 x13=4 -> x14 -----
    tab_instr[0]  = mk_r(7'h00, 3'b001); tab_exp[0]  = 32'hFFFFFF00;
    tab_instr[1]  = mk_r(7'h00, 3'b010); tab_exp[1]  = 32'h00000001;
    tab_instr[2]  = mk_r(7'h00, 3'b011); tab_exp[2]  = 32'h00000000;
    tab_instr[3]  = mk_r(7'h00, 3'b100); tab_exp[3]  = 32'hFFFFFFF4;
    tab_instr[4]  = mk_r(7'h00, 3'b101); tab_exp[4]  = 32'h0FFFFFFF;
    tab_instr[5]  = mk_r(7'h20, 3'b101); tab_exp[5]  = 32'hFFFFFFFF;
    tab_instr[6]  = mk_r(7'h00, 3'b110); tab_exp[6]  = 32'hFFFFFFF4;
    tab_instr[7]  = mk_r(7'h00, 3'b111); tab_exp[7]  = 32'h00000000;
    tab_instr[8]  = mk_i(12'h401, 3'b101); tab_exp[8]  = 32'hFFFFFFF8;
    tab_instr[9]  = mk_i(12'h400, 3'b000); tab_exp[9]  = 32'h000003F0;
    tab_instr[10] = mk_i(12'hFFF, 3'b100); tab_exp[10] = 32'h0000000F;
    for (int t = 0; t < 11; t++) begin
      hold();
      clear_mem();
      dut.memory.M[0] = tab_instr[t];
      dut.core.RegFile.RFMem[12] = 32'hFFFFFFF0;
      dut.core.RegFile.RFMem[13] = 32'h00000004;
      dut.core.RegFile.RFMem[14] = 32'h5A5A5A5A;
      expect_val($sformatf("alu_tab%0d", t), tab_exp[t]);
      reset = 1'b0;
      ticks(5);
      check(dut.core.RegFile.RFMem[14]);
    end

    n_total++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
